// File: rtl/fractal_sync_pkg.sv
// rtl/fractal_sync_pkg.sv - shared types for the fractal_sync counting CAM
package fractal_sync_pkg;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_DUP_PORT,
      ERR_TGT_MISMATCH,
      ERR_TGT_ZERO
   } err_cause_e;

   localparam int N_ERR_CAUSES = 4;

   typedef enum logic {
      LINE_FREE,
      LINE_WAIT
   } line_state_e;

endpackage

// File: rtl/fractal_sync_mp_cnt_cam_line.sv
// rtl/fractal_sync_mp_cnt_cam_line.sv - one CAM line: barrier signature, arrival count, target and port mask
module fractal_sync_mp_cnt_cam_line
   import fractal_sync_pkg::*;
#(
   parameter int SIG_WIDTH = 8,
   parameter int N_PORTS   = 4,
   parameter int CNT_WIDTH = 3
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              alloc,
   input  logic [SIG_WIDTH-1:0]              alloc_sig,
   input  logic [CNT_WIDTH-1:0]              alloc_count,
   input  logic [CNT_WIDTH-1:0]              alloc_target,
   input  logic [N_PORTS-1:0]                alloc_mask,
   input  logic                              arrive,
   input  logic [N_PORTS-1:0]                arrive_mask,
   input  logic [N_PORTS-1:0][SIG_WIDTH-1:0] lookup_sig,
   output logic                              valid,
   output logic [CNT_WIDTH-1:0]              target,
   output logic [N_PORTS-1:0]                mask,
   output logic [N_PORTS-1:0]                match,
   output logic                              complete,
   output logic [N_PORTS-1:0]                done_mask
);

   line_state_e            state_q, state_d;
   logic [SIG_WIDTH-1:0]   sig_q, sig_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic [CNT_WIDTH-1:0]   target_q, target_d;
   logic [N_PORTS-1:0]     mask_q, mask_d;
   int                     sum;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= LINE_FREE;
         sig_q    <= '0;
         count_q  <= '0;
         target_q <= '0;
         mask_q   <= '0;
      end else begin
         state_q  <= state_d;
         sig_q    <= sig_d;
         count_q  <= count_d;
         target_q <= target_d;
         mask_q   <= mask_d;
      end
   end

   // Ports already in the mask are counted once, so repeat arrivals never advance the count.
   always_comb begin
      state_d   = state_q;
      sig_d     = sig_q;
      count_d   = count_q;
      target_d  = target_q;
      mask_d    = mask_q;
      complete  = 1'b0;
      done_mask = mask_q | arrive_mask;
      sum       = int'(count_q) + $countones(arrive_mask & ~mask_q);
      case (state_q)
         LINE_FREE: begin
            if (alloc) begin
               state_d  = LINE_WAIT;
               sig_d    = alloc_sig;
               count_d  = alloc_count;
               target_d = alloc_target;
               mask_d   = alloc_mask;
            end
         end
         LINE_WAIT: begin
            if (arrive) begin
               if (sum >= int'(target_q)) begin
                  complete = 1'b1;
                  state_d  = LINE_FREE;
                  sig_d    = '0;
                  count_d  = '0;
                  target_d = '0;
                  mask_d   = '0;
               end else begin
                  count_d = CNT_WIDTH'(sum);
                  mask_d  = mask_q | arrive_mask;
               end
            end
         end
         default: state_d = LINE_FREE;
      endcase
   end

   assign valid  = (state_q == LINE_WAIT);
   assign target = target_q;
   assign mask   = mask_q;

   always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
         match[p] = valid && (sig_q == lookup_sig[p]);
      end
   end

endmodule

// File: rtl/fractal_sync_mp_cnt_cam.sv
// rtl/fractal_sync_mp_cnt_cam.sv - multi-port counting CAM for K-arrival fractal barriers
module fractal_sync_mp_cnt_cam
   import fractal_sync_pkg::*;
#(
   parameter int  N_LINES   = 4,
   parameter int  SIG_WIDTH = 8,
   parameter int  N_PORTS   = 4,
   localparam int CNT_WIDTH = $clog2(N_PORTS + 1),
   localparam int OCC_WIDTH = $clog2(N_LINES + 1)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [N_PORTS-1:0]                check_i,
   input  logic [N_PORTS-1:0][SIG_WIDTH-1:0] sig_i,
   input  logic [N_PORTS-1:0]                sig_valid_i,
   input  logic [N_PORTS-1:0][CNT_WIDTH-1:0] target_i,
   output logic [N_PORTS-1:0]                ready_o,
   output logic [N_PORTS-1:0]                present_o,
   output logic [N_PORTS-1:0]                done_o,
   output logic                              err_o,
   output logic [OCC_WIDTH-1:0]              occupancy_o
);

   logic [N_LINES-1:0]                line_valid, line_alloc, line_arrive, line_complete;
   logic [N_LINES-1:0][N_PORTS-1:0]   line_match, line_mask, line_done_mask, arrive_mask, alloc_mask;
   logic [N_LINES-1:0][CNT_WIDTH-1:0] line_target, alloc_count, alloc_target;
   logic [N_LINES-1:0][SIG_WIDTH-1:0] alloc_sig;

   logic [N_PORTS-1:0]                active, is_leader, hit, done_imm, done_d;
   logic [N_PORTS-1:0][N_PORTS-1:0]   group;
   logic [N_PORTS-1:0][CNT_WIDTH-1:0] tgt_eff;
   logic [N_ERR_CAUSES-1:0]           err_flags;
   int                                occ_next;

   for (genvar l = 0; l < N_LINES; l++) begin : g_line
      fractal_sync_mp_cnt_cam_line #(
         .SIG_WIDTH (SIG_WIDTH),
         .N_PORTS   (N_PORTS),
         .CNT_WIDTH (CNT_WIDTH)
      ) u_line (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .alloc        (line_alloc[l]),
         .alloc_sig    (alloc_sig[l]),
         .alloc_count  (alloc_count[l]),
         .alloc_target (alloc_target[l]),
         .alloc_mask   (alloc_mask[l]),
         .arrive       (line_arrive[l]),
         .arrive_mask  (arrive_mask[l]),
         .lookup_sig   (sig_i),
         .valid        (line_valid[l]),
         .target       (line_target[l]),
         .mask         (line_mask[l]),
         .match        (line_match[l]),
         .complete     (line_complete[l]),
         .done_mask    (line_done_mask[l])
      );
   end

   // A group is led by its lowest-index port; only leaders act on the lines.
   always_comb begin
      active = check_i & sig_valid_i;
      for (int p = 0; p < N_PORTS; p++) begin
         tgt_eff[p]   = (target_i[p] == '0) ? CNT_WIDTH'(1) : target_i[p];
         hit[p]       = 1'b0;
         for (int l = 0; l < N_LINES; l++) begin
            hit[p] = hit[p] | line_match[l][p];
         end
         present_o[p] = sig_valid_i[p] & hit[p];
         is_leader[p] = active[p];
         group[p]     = '0;
         for (int q = 0; q < N_PORTS; q++) begin
            if (active[q] && (sig_i[q] == sig_i[p])) begin
               if (q < p) is_leader[p] = 1'b0;
               else       group[p][q]  = 1'b1;
            end
         end
      end
   end

   always_comb begin : serve
      logic found;
      int   n;
      found        = 1'b0;
      n            = 0;
      line_alloc   = '0;
      alloc_sig    = '0;
      alloc_count  = '0;
      alloc_target = '0;
      alloc_mask   = '0;
      line_arrive  = '0;
      arrive_mask  = '0;
      ready_o      = '0;
      done_imm     = '0;
      err_flags    = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (active[p] && (target_i[p] == '0)) err_flags[ERR_TGT_ZERO] = 1'b1;
         if (is_leader[p]) begin
            n = $countones(group[p]);
            if (hit[p]) begin
               ready_o = ready_o | group[p];
               for (int l = 0; l < N_LINES; l++) begin
                  if (line_match[l][p]) begin
                     line_arrive[l] = 1'b1;
                     arrive_mask[l] = group[p];
                     if (|(group[p] & line_mask[l])) err_flags[ERR_DUP_PORT] = 1'b1;
                     for (int q = 0; q < N_PORTS; q++) begin
                        if (group[p][q] && (tgt_eff[q] != line_target[l]))
                           err_flags[ERR_TGT_MISMATCH] = 1'b1;
                     end
                  end
               end
            end else if (n >= int'(tgt_eff[p])) begin
               ready_o  = ready_o | group[p];
               done_imm = done_imm | group[p];
            end else begin
               // Lines completing this cycle still read valid, so they are not reused until next cycle.
               found = 1'b0;
               for (int l = 0; l < N_LINES; l++) begin
                  if (!found && !line_valid[l] && !line_alloc[l]) begin
                     found           = 1'b1;
                     line_alloc[l]   = 1'b1;
                     alloc_sig[l]    = sig_i[p];
                     alloc_count[l]  = CNT_WIDTH'(n);
                     alloc_target[l] = tgt_eff[p];
                     alloc_mask[l]   = group[p];
                  end
               end
               if (found) ready_o = ready_o | group[p];
            end
         end
      end
   end

   always_comb begin
      done_d   = done_imm;
      occ_next = 0;
      for (int l = 0; l < N_LINES; l++) begin
         if (line_complete[l]) done_d = done_d | line_done_mask[l];
         if ((line_valid[l] && !line_complete[l]) || line_alloc[l]) occ_next = occ_next + 1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_o      <= '0;
         err_o       <= 1'b0;
         occupancy_o <= '0;
      end else begin
         done_o      <= done_d;
         err_o       <= |err_flags;
         occupancy_o <= OCC_WIDTH'(occ_next);
      end
   end

   always_comb begin : match_check
      int hits;
      hits = 0;
      assert (N_PORTS >= 2);
      assert (N_LINES >= 1);
      for (int p = 0; p < N_PORTS; p++) begin
         hits = 0;
         for (int l = 0; l < N_LINES; l++) hits = hits + int'(line_match[l][p]);
         if (rst_ni) assert (hits <= 1);
      end
   end

endmodule
